// File: rtl/spi_reg_master.sv
// SPI mode-3 initiator for the 40-bit register-access frame {wr_data, rw, addr}.
// SCK, MOSI and CS are registered outputs derived from the system clock.
module spi_reg_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BIT_LO,
    BIT_HI,
    HOLD,
    GAP
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] tx;
  logic [39:0] rx;

  // cnt times every phase; bit_cnt tracks which of the 40 bits is on the wire.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      sck     <= 1'b1;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx      <= {wr_data, rw, addr};
            bit_cnt <= '0;
            cnt     <= '0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            sck   <= 1'b0;
            mosi  <= tx[39];
            state <= BIT_LO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BIT_LO: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            sck   <= 1'b1;
            rx    <= {rx[38:0], miso};
            state <= BIT_HI;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BIT_HI: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // The final bit leaves SCK high so the frame ends on a rising edge.
            if (bit_cnt == 6'd39) begin
              state <= HOLD;
            end else begin
              sck     <= 1'b0;
              tx      <= {tx[38:0], 1'b0};
              mosi    <= tx[38];
              bit_cnt <= bit_cnt + 6'd1;
              state   <= BIT_LO;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            rd_data <= rx[39:8];
            state   <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == IDLE_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Scoreboard bench for spi_reg_master: default-timing instance plus a minimum-timing instance.
module tb_spi_reg_master;

  localparam int DONE_LAT = 325;

  logic        clk = 1'b0;
  logic        rst, start, rw, miso, busy, done, sck, mosi, cs_n;
  logic [6:0]  addr;
  logic [31:0] wr_data, rd_data;

  logic        start_f, rw_f, miso_f, busy_f, done_f, sck_f, mosi_f, cs_n_f;
  logic [6:0]  addr_f;
  logic [31:0] wr_data_f, rd_data_f;

  spi_reg_master dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wr_data(wr_data),
    .busy(busy), .done(done), .rd_data(rd_data), .sck(sck), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  spi_reg_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut_fast (
    .clk(clk), .rst(rst), .start(start_f), .rw(rw_f), .addr(addr_f), .wr_data(wr_data_f),
    .busy(busy_f), .done(done_f), .rd_data(rd_data_f), .sck(sck_f), .mosi(mosi_f),
    .miso(miso_f), .cs_n(cs_n_f)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] frame;
    logic [31:0] rd;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] resp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slave model: takes the next response word at CS fall, shifts it out on SCK falls.
  logic [39:0] cur_resp = '0;
  int          sidx = 0;
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge sck or negedge cs_n);
      if (mon_en && !cs_n && sck) begin
        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 40'd0;
        sidx = 0;
      end else if (mon_en && !cs_n && !sck && sidx < 40) begin
        miso = cur_resp[39 - sidx];
        sidx++;
      end
    end
  end

  // Monitor: tracks per-frame timing and MOSI bits, checks against the scoreboard on done.
  logic        prev_sck = 1'b1, prev_cs_n = 1'b1;
  int          rises = 0, fall_cyc = 0, first_fall = -1, last_rise = 0;
  logic [39:0] sh = '0;
  exp_t        e;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (prev_cs_n && !cs_n) begin
        rises = 0; sh = '0; fall_cyc = cyc; first_fall = -1;
      end
      if (!cs_n && prev_sck && !sck && first_fall < 0) first_fall = cyc;
      if (!cs_n && !prev_sck && sck) begin
        rises++;
        sh = {sh[38:0], mosi};
        last_rise = cyc;
      end
      if (cs_n) check_output("sck_idle_high", 64'(sck), 64'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("done_cycle", 64'(cyc), 64'(e.acc + DONE_LAT));
          check_output("cs_fall_cycle", 64'(fall_cyc), 64'(e.acc + 1));
          check_output("first_sck_fall", 64'(first_fall), 64'(e.acc + 3));
          check_output("last_sck_rise", 64'(last_rise), 64'(e.acc + 319));
          check_output("sck_rises", 64'(rises), 64'd40);
          check_output("mosi_frame", 64'(sh), 64'(e.frame));
          check_output("rd_data", 64'(rd_data), 64'(e.rd));
          check_output("mosi_low_at_done", 64'(mosi), 64'd0);
          check_output("cs_n_high_at_done", 64'(cs_n), 64'd1);
        end
      end
      prev_sck  = sck;
      prev_cs_n = cs_n;
    end
  end

  logic prev_sck_f = 1'b1, prev_cs_f = 1'b1;
  int   rises_f = 0, ones_f = 0, last_rise_f = 0;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (prev_cs_f && !cs_n_f) begin
        rises_f = 0; ones_f = 0;
      end
      if (!cs_n_f && !prev_sck_f && sck_f) begin
        rises_f++;
        if (mosi_f) ones_f++;
        last_rise_f = cyc;
      end
      prev_sck_f = sck_f;
      prev_cs_f  = cs_n_f;
    end
  end

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic apply_stimulus(input logic r, input logic [6:0] a, input logic [31:0] d,
                                input logic [39:0] resp, input logic [39:0] frame,
                                input bit expect_done, output int acc);
    rw = r; addr = a; wr_data = d; start = 1'b1;
    acc = cyc;
    resp_q.push_back(resp);
    if (expect_done) exp_q.push_back('{frame: frame, rd: resp[39:8], acc: acc});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("wait_idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  int a0, a1;
  bit got;
  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wr_data = '0;
    start_f = 1'b0; rw_f = 1'b0; addr_f = '0; wr_data_f = '0; miso_f = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_sck", 64'(sck), 64'd1);
    check_output("rst_cs_n", 64'(cs_n), 64'd1);
    check_output("rst_mosi", 64'(mosi), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_rd_data", 64'(rd_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Write frame: MOSI must carry 0x1234567585.
    apply_stimulus(1'b1, 7'h05, 32'h12345675, 40'hCAFEF00D11, 40'h1234567585, 1'b1, a0);
    at_cycle(a0 + 1);
    check_output("busy_after_accept", 64'(busy), 64'd1);
    at_cycle(a0 + 328);
    check_output("busy_before_gap_end", 64'(busy), 64'd1);
    at_cycle(a0 + 329);
    check_output("busy_low_at_329", 64'(busy), 64'd0);
    check_output("rd_data_held", 64'(rd_data), 64'hCAFEF00D);
    wait_idle(50);

    // Read frame with start pulses during the frame and in the done cycle.
    apply_stimulus(1'b0, 7'h2A, 32'h0, 40'hDEADBEEFFF, 40'h000000002A, 1'b1, a0);
    at_cycle(a0 + 10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    at_cycle(a0 + 325);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    at_cycle(a0 + 326);
    check_output("read_rd_data_held", 64'(rd_data), 64'hDEADBEEF);
    at_cycle(a0 + 331);
    check_output("ignored_start_busy", 64'(busy), 64'd0);
    check_output("ignored_start_cs_n", 64'(cs_n), 64'd1);
    wait_idle(50);

    // Continuous start: second frame accepted the cycle busy falls.
    rw = 1'b1; addr = 7'h11; wr_data = 32'hA5A5A5A5; start = 1'b1;
    a0 = cyc;
    a1 = a0 + 329;
    resp_q.push_back(40'h0123456789);
    resp_q.push_back(40'h89ABCDEF01);
    exp_q.push_back('{frame: 40'hA5A5A5A591, rd: 32'h01234567, acc: a0});
    exp_q.push_back('{frame: 40'hA5A5A5A591, rd: 32'h89ABCDEF, acc: a1});
    at_cycle(a1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(400);

    // Reset mid-frame: outputs return to reset values, no done.
    apply_stimulus(1'b1, 7'h33, 32'h55AA55AA, 40'h1111111111, 40'h55AA55AAB3, 1'b0, a0);
    at_cycle(a0 + 150);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    at_cycle(a0 + 151);
    check_output("midrst_cs_n", 64'(cs_n), 64'd1);
    check_output("midrst_sck", 64'(sck), 64'd1);
    check_output("midrst_mosi", 64'(mosi), 64'd0);
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_rd_data", 64'(rd_data), 64'd0);
    @(posedge clk); #1;

    // Reset and start together: start is dropped.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_output("rst_start_busy", 64'(busy), 64'd0);
    check_output("rst_start_cs_n", 64'(cs_n), 64'd1);
    repeat (5) @(posedge clk);
    #1;

    apply_stimulus(1'b0, 7'h7E, 32'hFFFF0000, 40'h0F0F0F0FAA, 40'hFFFF00007E, 1'b1, a0);
    wait_idle(400);

    // Minimum-timing instance: all-ones write, done 83 cycles after accept.
    rw_f = 1'b1; addr_f = 7'h7F; wr_data_f = 32'hFFFFFFFF; start_f = 1'b1;
    a0 = cyc;
    @(posedge clk); #1;
    start_f = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_f) begin
        got = 1'b1;
        break;
      end
    end
    check_output("fast_done_seen", 64'(got), 64'd1);
    check_output("fast_done_cycle", 64'(cyc), 64'(a0 + 83));
    check_output("fast_rd_data", 64'(rd_data_f), 64'hFFFFFFFF);
    check_output("fast_sck_rises", 64'(rises_f), 64'd40);
    check_output("fast_mosi_ones", 64'(ones_f), 64'd40);
    check_output("fast_last_rise", 64'(last_rise_f), 64'(a0 + 81));

    repeat (10) @(posedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI initiator for the 40-bit register-access frame that the FPGA register-file slave decodes.
- Used by the FPGA-side bench and by internal bring-up logic to issue register writes and reads: {data[31:0], rw, addr[6:0]}.
- Drives SCK, MOSI and active-low CS, samples MISO, and returns the 32-bit response word with a done pulse.
- Clocked entirely from the system clock; SCK is a divided, registered output.

Parameters:
- CLK_DIV, 4, system clocks per SCK half-period (>=1)
- CS_SETUP, 2, clocks from CS falling to first SCK falling edge (>=1)
- CS_HOLD, 2, clocks from last SCK rising edge to CS rising (>=1)
- CS_IDLE, 4, minimum clocks CS stays high between frames (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; accepted only when busy=0
- rw  in  1  1=write, 0=read; captured at accept
- addr  in  7  register address; captured at accept
- wr_data  in  32  write payload; captured at accept (don't-care for reads, still shifted)
- busy  out  1  high from the cycle after accept through the end of the idle gap
- done  out  1  one-cycle pulse at frame end
- rd_data  out  32  response word; valid from the done cycle, held until the next done
- sck  out  1  SPI clock, idles high
- mosi  out  1  master data out
- miso  in  1  slave data in
- cs_n  out  1  chip select, active low

Behaviour:
- Reset values: sck=1, cs_n=1, mosi=0, busy=0, done=0, rd_data=0, FSM=IDLE.
- SPI mode 3:
  - SCK idles high.
  - MOSI changes only in the cycle SCK goes low.
  - Master samples MISO in the cycle SCK goes high; the slave samples MOSI on the SCK rising edge.
- Frame: 40 bits, MSB first, tx shift = {wr_data[31:0], rw, addr[6:0]}. wr_data[31] goes first; addr[0] goes last.
- rx shift: 40 bits, MSB first. rd_data = rx[39:8] (first 32 bits received); last 8 MISO bits are discarded.
- Read data is pipelined by the slave: a read frame returns the word requested by the previous read. Software issues read(addr) then any frame to collect it. This block does no correction.
- FSM states: IDLE -> SETUP -> BIT_LO -> BIT_HI -> (BIT_LO | HOLD) -> GAP -> IDLE.
- IDLE: when start=1, latch the inputs, load tx, clear the bit counter (6 bits, 0..39), and go to SETUP. cs_n=0 and busy=1 take effect next cycle (cycle 1, with accept at cycle 0).
- SETUP: CS_SETUP clocks with sck=1. Then sck=0 and mosi=tx[39] → BIT_LO.
- BIT_LO: CLK_DIV clocks. Then sck=1, rx <= {rx[38:0], miso} → BIT_HI.
- BIT_HI: CLK_DIV clocks.
  - If the bit counter is 39: go to HOLD with sck held at 1.
  - Otherwise: sck=0, shift tx left, mosi=next bit, increment the counter → BIT_LO.
- HOLD: CS_HOLD clocks. Then cs_n=1, done=1 (single cycle), rd_data updated in the same cycle → GAP.
- GAP: CS_IDLE clocks with cs_n=1. Then busy=0 → IDLE.
- Timing with defaults, accept at cycle 0:
  - cs_n low at cycle 1.
  - First SCK fall at cycle 3.
  - Last SCK rise at cycle 319.
  - cs_n high and done at cycle 325.
  - busy low at cycle 329.
  - General formula: done cycle = 1 + CS_SETUP + 80*CLK_DIV + CS_HOLD.
- start while busy=1 (including the done cycle) is ignored and not queued. start in the same cycle busy falls is accepted.
- Exactly 40 SCK falling and 40 rising edges per frame. No SCK activity while cs_n=1.
- MOSI returns to 0 when cs_n rises.
- rst mid-frame: next cycle all outputs return to reset values (cs_n=1 aborts the frame at the slave). No done pulse; rd_data=0.
- rst and start in the same cycle: rst wins; start is dropped.

Test Plan:
- Write: start, rw=1, addr=0x05, wr_data=0x12345675 → MOSI at the 40 SCK rises = bits of 0x1234567585. done at cycle 325; cs_n low cycles 1..324.
- Read response: miso model drives 0xDEADBEEF MSB first over bits 0..31, then 0xFF → rd_data=0xDEADBEEF at the done cycle, held until the next done.
- start pulsed at cycles 10 and 325 during a frame → ignored. Exactly 40 SCK rises, one done.
- start asserted continuously → back-to-back frames with cs_n high for exactly CS_IDLE+1 clocks between them. Each frame produces 40 SCK rises.
- rst at cycle 150 mid-frame → cycle 151: cs_n=1, sck=1, mosi=0, busy=0. No done; rd_data=0. A new start then produces a complete, correct frame.
- CLK_DIV=1, CS_SETUP=CS_HOLD=CS_IDLE=1, write addr=0x7F, wr_data=0xFFFFFFFF, rw=1 → SCK period 2 clocks, 40 MOSI ones. done at cycle 83.
